// File: rtl/loader_pkg.sv
// loader_pkg: state encoding, frame constants and field widths shared by the program loader.
package loader_pkg;
    localparam int BYTE_W = 8;
    localparam int LEN_W = 16;
    localparam logic [BYTE_W-1:0] MAGIC_DEFAULT = 8'hA5;
    typedef enum logic [3:0] {
        ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_B2, ST_B1, ST_B0, ST_WRITE, ST_CSUM, ST_DONE, ST_ERR
    } state_t;
endpackage

// File: rtl/loader_word_asm.sv
// loader_word_asm: shifts three big-endian bytes into one instruction word and flags a B2 byte
// whose bits above the word width are set.
module loader_word_asm
    import loader_pkg::*;
#(
    parameter int W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              take,
    input  logic              first,
    input  logic [BYTE_W-1:0] data,
    output logic [W-1:0]      word,
    output logic              bad
);
    assign bad = first && |data[BYTE_W-1:W-16];
    // Older bytes fall off the top, so after B0 only the low W bits of {B2,B1,B0} remain.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) word <= '0;
        else if (take) word <= {word[W-BYTE_W-1:0], data};
endmodule

// File: rtl/prog_loader.sv
// prog_loader: frames a byte stream into instruction words and writes them from address 0,
// holding the CPU in reset until a clean load. PROG_LOADER_CHECKSUM_EN adds the trailing XOR byte.
module prog_loader
    import loader_pkg::*;
#(
    parameter int              INSTRUCTION_WIDTH = 18,
    parameter int              PC_WIDTH          = 14,
    parameter logic [BYTE_W-1:0] MAGIC           = MAGIC_DEFAULT
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_rx_valid,
    input  logic [BYTE_W-1:0]            i_rx_data,
    output logic                         o_rx_ready,
    input  logic                         i_start,
    output logic                         o_mem_we,
    output logic [PC_WIDTH-1:0]          o_mem_addr,
    output logic [INSTRUCTION_WIDTH-1:0] o_mem_wdata,
    output logic                         o_cpu_rst,
    output logic                         o_done,
    output logic                         o_err
);
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t TAIL = ST_CSUM;
    logic [BYTE_W-1:0] csum;
`else
    localparam state_t TAIL = ST_DONE;
`endif
    state_t state, state_nx;
    logic [LEN_W-1:0] len, full_len;
    logic [PC_WIDTH:0] idx;
    logic fire, take_word, bad, last, rearm;

    assign o_rx_ready = i_rst && (state inside {ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_B2, ST_B1, ST_B0, ST_CSUM});
    assign fire = i_rx_valid && o_rx_ready;
    assign take_word = fire && (state inside {ST_B2, ST_B1, ST_B0});
    assign full_len = {len[LEN_W-1:BYTE_W], i_rx_data};
    // idx is one bit wider than the address so a full-memory load never wraps back to 0.
    assign last = 32'(idx) + 32'd1 == 32'(len);
    assign rearm = i_start && (state inside {ST_DONE, ST_ERR});
    assign o_mem_we = state == ST_WRITE;
    assign o_mem_addr = idx[PC_WIDTH-1:0];
    assign o_cpu_rst = state != ST_DONE;
    assign o_done = state == ST_DONE;
    assign o_err = state == ST_ERR;

    loader_word_asm #(.W(INSTRUCTION_WIDTH)) u_asm (
        .clk(i_clk),
        .rst_n(i_rst),
        .take(take_word),
        .first(state == ST_B2),
        .data(i_rx_data),
        .word(o_mem_wdata),
        .bad(bad)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (fire && i_rx_data == MAGIC) state_nx = ST_LEN_HI;
            ST_LEN_HI: if (fire) state_nx = ST_LEN_LO;
            ST_LEN_LO: if (fire) state_nx = 32'(full_len) > (32'd1 << PC_WIDTH) ? ST_ERR :
                                            full_len == '0 ? TAIL : ST_B2;
            ST_B2:     if (fire) state_nx = bad ? ST_ERR : ST_B1;
            ST_B1:     if (fire) state_nx = ST_B0;
            ST_B0:     if (fire) state_nx = ST_WRITE;
            ST_WRITE:  state_nx = last ? TAIL : ST_B2;
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CSUM:   if (fire) state_nx = i_rx_data == csum ? ST_DONE : ST_ERR;
`endif
            ST_DONE, ST_ERR: if (i_start) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_IDLE;
            len <= '0;
            idx <= '0;
        end else begin
            state <= state_nx;
            if (rearm) len <= '0;
            else if (fire && state == ST_LEN_HI) len <= {i_rx_data, {BYTE_W{1'b0}}};
            else if (fire && state == ST_LEN_LO) len <= full_len;
            if (rearm) idx <= '0;
            else if (state == ST_WRITE) idx <= idx + 1'b1;
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) csum <= '0;
        else if (rearm) csum <= '0;
        else if (fire && (state inside {ST_LEN_HI, ST_LEN_LO, ST_B2, ST_B1, ST_B0})) csum <= csum ^ i_rx_data;
`endif
endmodule
